// File: rtl/start_screen_fetch.sv
// Start-screen pixel fetch: maps 640x480 VGA coordinates onto a 2x-scaled 320x240 4bpp ROM and blinks the text box.
// Fixed 3-cycle latency from DrawX/DrawY/blank to index/pixel_valid; no backpressure, one pixel accepted per clock.
module start_screen_fetch #(
  parameter int          IMG_W        = 320,
  parameter int          IMG_H        = 240,
  parameter int          BLINK_FRAMES = 30,
  parameter int          TEXT_X0      = 192,
  parameter int          TEXT_X1      = 448,
  parameter int          TEXT_Y0      = 352,
  parameter int          TEXT_Y1      = 384,
  parameter logic [3:0]  BG_INDEX     = 4'd0
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        blank,
  input  logic        vs,
  input  logic        start_active,
  output logic [16:0] rom_addr,
  input  logic [3:0]  rom_q,
  output logic [3:0]  index,
  output logic        pixel_valid,
  output logic        blink_on
);

  localparam int             CW       = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(BLINK_FRAMES - 1);

  typedef enum logic {SHOW, HIDE} blink_state_t;

  blink_state_t  r_state;
  blink_state_t  w_state_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic          r_vs_prev;
  logic          w_tick;

  logic          r_vis1, r_txt1, r_vis2, r_txt2;
  logic [16:0]   w_row_base;
  logic [16:0]   w_addr;
  logic          w_vis;
  logic          w_txt;

  // Halving both coordinates implements the 2x upscale; 17 bits holds the full 76799 range.
  assign w_row_base = 17'(DrawY >> 1) * 17'(IMG_W);
  assign w_addr     = w_row_base + 17'(DrawX >> 1);

  assign w_vis = blank & (DrawX < 10'(2 * IMG_W)) & (DrawY < 10'(2 * IMG_H));
  assign w_txt = (DrawX >= 10'(TEXT_X0)) & (DrawX < 10'(TEXT_X1)) &
                 (DrawY >= 10'(TEXT_Y0)) & (DrawY < 10'(TEXT_Y1));

  assign w_tick = r_vs_prev & ~vs;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rom_addr    <= '0;
      r_vis1      <= 1'b0;
      r_txt1      <= 1'b0;
      r_vis2      <= 1'b0;
      r_txt2      <= 1'b0;
      index       <= '0;
      pixel_valid <= 1'b0;
    end else begin
      rom_addr    <= w_addr;
      r_vis1      <= w_vis;
      r_txt1      <= w_txt;
      r_vis2      <= r_vis1;
      r_txt2      <= r_txt1;
      pixel_valid <= r_vis2;
      if (!r_vis2)
        index <= '0;
      else if (r_txt2 && !blink_on)
        index <= BG_INDEX;
      else
        index <= rom_q;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state   <= SHOW;
      r_cnt     <= '0;
      r_vs_prev <= 1'b1;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_vs_prev <= vs;
    end
  end

  // Dropping start_active wins over a coincident frame tick.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    blink_on     = (r_state == SHOW);
    if (!start_active) begin
      w_state_next = SHOW;
      w_cnt_next   = '0;
    end else if (w_tick) begin
      if (r_cnt == CNT_LAST) begin
        w_cnt_next   = '0;
        w_state_next = (r_state == SHOW) ? HIDE : SHOW;
      end else begin
        w_cnt_next = r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_start_screen_fetch.sv
// Directed bench for start_screen_fetch with a 1-cycle ROM model returning addr[3:0] or a forced value.
`timescale 1ns/1ps
module tb_start_screen_fetch;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic [9:0]  DrawX = '0;
  logic [9:0]  DrawY = '0;
  logic        blank = 1'b0;
  logic        vs = 1'b1;
  logic        start_active = 1'b0;
  logic [16:0] rom_addr;
  logic [3:0]  rom_q = '0;
  logic [3:0]  index;
  logic        pixel_valid;
  logic        blink_on;

  logic        rom_force = 1'b0;
  logic [3:0]  rom_val = '0;

  int checks = 0;
  int errors = 0;

  start_screen_fetch dut (
    .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .vs(vs), .start_active(start_active), .rom_addr(rom_addr), .rom_q(rom_q),
    .index(index), .pixel_valid(pixel_valid), .blink_on(blink_on)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) rom_q <= rom_force ? rom_val : rom_addr[3:0];

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pix(input int x, input int y, input logic b);
    DrawX = 10'(x);
    DrawY = 10'(y);
    blank = b;
  endtask

  task automatic tick();
    vs = 1'b0;
    step();
    vs = 1'b1;
    step();
  endtask

  initial begin
    // Asynchronous reset, checked before any clock edge
    #1 Reset = 1'b1;
    #1;
    chk("rst_rom_addr", 32'(rom_addr), 0);
    chk("rst_index", 32'(index), 0);
    chk("rst_pixel_valid", 32'(pixel_valid), 0);
    chk("rst_blink_on", 32'(blink_on), 1);
    step(2);
    Reset = 1'b0;

    // (5,3): addr = 1*320 + 2 = 322, index = 322 & 15 = 2
    pix(5, 3, 1'b1);
    step();
    chk("addr_5_3", 32'(rom_addr), 322);
    chk("pv_5_3_c1", 32'(pixel_valid), 0);
    step();
    chk("pv_5_3_c2", 32'(pixel_valid), 0);
    step();
    chk("idx_5_3", 32'(index), 2);
    chk("pv_5_3", 32'(pixel_valid), 1);

    // Far corner: 239*320 + 319 = 76799 = 0x12BFF
    pix(639, 479, 1'b1);
    step();
    chk("addr_corner", 32'(rom_addr), 76799);
    step(2);
    chk("idx_corner", 32'(index), 15);
    chk("pv_corner", 32'(pixel_valid), 1);

    // Off-screen and blanked: gated to zero
    pix(700, 479, 1'b0);
    step(3);
    chk("idx_offscreen", 32'(index), 0);
    chk("pv_offscreen", 32'(pixel_valid), 0);
    pix(700, 100, 1'b1);
    step(3);
    chk("idx_x700_vis", 32'(index), 0);
    chk("pv_x700_vis", 32'(pixel_valid), 0);

    // Blink: 30 ticks to HIDE; a held-low vs counts as one tick
    start_active = 1'b1;
    rom_force = 1'b1;
    rom_val = 4'd9;
    pix(200, 360, 1'b1);
    vs = 1'b0;
    step(5);
    vs = 1'b1;
    step();
    for (int i = 1; i < 29; i++) tick();
    chk("blink_after_29", 32'(blink_on), 1);
    step(3);
    chk("idx_text_show", 32'(index), 9);
    tick();
    chk("blink_after_30", 32'(blink_on), 0);
    step(3);
    chk("idx_text_hide", 32'(index), 0);
    chk("pv_text_hide", 32'(pixel_valid), 1);
    pix(100, 360, 1'b1);
    step(3);
    chk("idx_outside_text", 32'(index), 9);
    pix(200, 360, 1'b1);
    for (int i = 0; i < 29; i++) tick();
    chk("blink_hide_29", 32'(blink_on), 0);
    tick();
    chk("blink_back_show", 32'(blink_on), 1);
    step(3);
    chk("idx_text_reshow", 32'(index), 9);

    // Into HIDE, advance counter to 12, then drop start_active on a falling vs edge
    for (int i = 0; i < 30; i++) tick();
    chk("blink_hide_again", 32'(blink_on), 0);
    for (int i = 0; i < 12; i++) tick();
    vs = 1'b0;
    start_active = 1'b0;
    step();
    chk("blink_forced_show", 32'(blink_on), 1);
    vs = 1'b1;
    step();
    start_active = 1'b1;
    for (int i = 0; i < 29; i++) tick();
    chk("blink_cnt_cleared", 32'(blink_on), 1);
    tick();
    chk("blink_hide_after_30", 32'(blink_on), 0);

    // Mid-stream reset after 5 valid pixels
    start_active = 1'b0;
    rom_force = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pix(10 + i, 0, 1'b1);
      step();
    end
    chk("pv_before_reset", 32'(pixel_valid), 1);
    Reset = 1'b1;
    #1;
    chk("midrst_rom_addr", 32'(rom_addr), 0);
    chk("midrst_index", 32'(index), 0);
    chk("midrst_pv", 32'(pixel_valid), 0);
    chk("midrst_blink_on", 32'(blink_on), 1);
    step();
    Reset = 1'b0;
    // (20,2): addr = 1*320 + 10 = 330, index = 10
    pix(20, 2, 1'b1);
    step();
    chk("resume_addr", 32'(rom_addr), 330);
    chk("resume_c1_idx", 32'(index), 0);
    chk("resume_c1_pv", 32'(pixel_valid), 0);
    step();
    chk("resume_c2_idx", 32'(index), 0);
    chk("resume_c2_pv", 32'(pixel_valid), 0);
    step();
    chk("resume_c3_idx", 32'(index), 10);
    chk("resume_c3_pv", 32'(pixel_valid), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/start_screen_fetch.md
Name: start_screen_fetch

Overview:
- Pixel-fetch stage directly upstream of the start-screen palette lookup.
- Converts VGA controller coordinates into addresses for a 320x240, 4-bit-per-pixel start-screen image ROM, scaled 2x to 640x480.
- Registers the returned colour index and gates it with delayed blanking.
- Blinks a rectangular "PRESS START" text region on a vsync-driven frame counter.
- Feeds `index` straight into the palette lookup stage.

Parameters:
- IMG_W, 320, source image width in pixels.
- IMG_H, 240, source image height in pixels.
- BLINK_FRAMES, 30, frames per blink half-period; must be at least 1.
- TEXT_X0, 192, text region left edge, screen pixels, inclusive.
- TEXT_X1, 448, text region right edge, exclusive.
- TEXT_Y0, 352, text region top edge, inclusive.
- TEXT_Y1, 384, text region bottom edge, exclusive.
- BG_INDEX, 0, palette index substituted in the text region while hidden.

Ports:
- Clk  in  1  pixel clock.
- Reset  in  1  asynchronous, active-high reset.
- DrawX  in  10  current screen column, 0..799.
- DrawY  in  10  current screen row, 0..524.
- blank  in  1  1 = visible video region.
- vs  in  1  vertical sync, active-low.
- start_active  in  1  1 = start screen shown; enables blinking.
- rom_addr  out  17  image ROM read address; the ROM has 1-cycle synchronous read latency.
- rom_q  in  4  ROM data, valid one cycle after rom_addr.
- index  out  4  palette index to the palette stage.
- pixel_valid  out  1  index corresponds to a visible on-screen pixel.
- blink_on  out  1  current text visibility phase, for debug/LED.

Behaviour:
- Reset (async, immediate):
  - rom_addr=0, index=0, pixel_valid=0, blink_on=1.
  - Frame counter=0; vs_prev=1; all pipeline valid/region flags=0.
- Pipeline, fixed 3-cycle latency from DrawX/DrawY/blank to index/pixel_valid:
  - Cycle 1: rom_addr <= (DrawY>>1)*IMG_W + (DrawX>>1), computed in 17 bits with no truncation (max 239*320+319=76799). Same cycle, register vis1 = blank & (DrawX<640) & (DrawY<480), and txt1 = coordinate inside text rectangle.
  - Cycle 2: ROM presents rom_q. Delay vis1 to vis2 and txt1 to txt2.
  - Cycle 3: index <= !vis2 ? 0 : (txt2 & !blink_on) ? BG_INDEX : rom_q. pixel_valid <= vis2.
- Off-screen coordinates: rom_addr is still computed but is don't-care; index is forced to 0 through the vis gating.
- Blink machine, two states SHOW (blink_on=1) and HIDE (blink_on=0):
  - vs_prev registers vs each cycle; a frame tick occurs on the cycle where vs_prev=1 and vs=0.
  - On a tick with start_active=1: if counter == BLINK_FRAMES-1, set counter=0 and toggle state; else counter+1.
  - start_active=0 forces counter=0 and state SHOW every cycle, overriding any simultaneous tick.
  - The blink_on change takes effect on index at the next pipeline stage-3 update; no frame alignment beyond the vs edge is required.
- Held vs low: exactly one tick per falling edge.
- Reset mid-frame: pipeline flushes to zeros. First valid index appears 3 cycles after Reset deasserts with blank=1.

Test Plan:
- Reset → rom_addr=0, index=0, pixel_valid=0, blink_on=1 immediately, without a clock edge.
- DrawX=5, DrawY=3, blank=1; ROM model returns addr[3:0] → rom_addr=322 after 1 cycle; index=322&15=2 and pixel_valid=1 after 3 cycles.
- DrawX=639, DrawY=479 → rom_addr=76799. Then DrawX=700, blank=0 → index=0, pixel_valid=0 three cycles later.
- start_active=1, 30 vs falling edges → blink_on falls on the 30th tick. Pixel (200,360) with rom_q=9 → index=0 (BG_INDEX). Pixel (100,360) → index=9. 30 further ticks → blink_on=1, and (200,360) outputs 9.
- In HIDE state with counter=12, drop start_active coincident with a vs falling edge → next cycle blink_on=1, counter=0. Re-raise start_active → 30 ticks needed before the next HIDE.
- Assert Reset for 1 cycle mid-stream after 5 valid pixels → outputs zero immediately. Resuming pixels appear with exactly 3-cycle latency, and no stale index leaks.
